// File: rtl/div_pkg.sv
// Shared encodings for the iterative divide/remainder unit.
package div_pkg;

  localparam logic [1:0] OP_DIV  = 2'b00;
  localparam logic [1:0] OP_DIVU = 2'b01;
  localparam logic [1:0] OP_REM  = 2'b10;
  localparam logic [1:0] OP_REMU = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    DONE = 2'b10
  } state_e;

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring division iteration on {rem, quot}; purely combinational.
module div_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH:0]   rem,
  input  logic [WIDTH-1:0] quot,
  input  logic [WIDTH-1:0] dvsr,
  output logic [WIDTH:0]   rem_next,
  output logic [WIDTH-1:0] quot_next
);

  logic [WIDTH+1:0] shifted;
  logic [WIDTH+1:0] diff;

  always_comb begin
    shifted = {rem, quot[WIDTH-1]};
    diff    = shifted - {2'b00, dvsr};
    // Top bit of diff is the borrow: restore and shift in a zero.
    if (diff[WIDTH+1]) begin
      rem_next  = shifted[WIDTH:0];
      quot_next = {quot[WIDTH-2:0], 1'b0};
    end else begin
      rem_next  = diff[WIDTH:0];
      quot_next = {quot[WIDTH-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/iter_divider.sv
// Multi-cycle signed/unsigned divide/remainder, one quotient bit per clock,
// with RISC-V corner-case results for divide-by-zero and signed overflow.
module iter_divider
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             result_valid,
  input  logic             result_ready,
  output logic [WIDTH-1:0] result,
  output logic             busy
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  state_e           state;
  logic [1:0]       op_q;
  logic [WIDTH:0]   rem;
  logic [WIDTH-1:0] quot;
  logic [WIDTH-1:0] dvsr;
  logic             quot_neg;
  logic             rem_neg;
  logic [CNT_W-1:0] cnt;

  logic             in_signed;
  logic             in_rem;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH:0]   rem_next;
  logic [WIDTH-1:0] quot_next;
  logic [WIDTH-1:0] rem_fin;

  always_comb begin
    in_signed = (op == OP_DIV) || (op == OP_REM);
    in_rem    = (op == OP_REM) || (op == OP_REMU);
    a_mag     = (in_signed && dividend[WIDTH-1]) ? -dividend : dividend;
    b_mag     = (in_signed && divisor[WIDTH-1])  ? -divisor  : divisor;
    rem_fin   = rem_next[WIDTH-1:0];
  end

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem       (rem),
    .quot      (quot),
    .dvsr      (dvsr),
    .rem_next  (rem_next),
    .quot_next (quot_next)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      op_q     <= '0;
      rem      <= '0;
      quot     <= '0;
      dvsr     <= '0;
      quot_neg <= 1'b0;
      rem_neg  <= 1'b0;
      cnt      <= '0;
      result   <= '0;
    end else if (flush) begin
      state <= IDLE;
    end else begin
      unique case (state)
        IDLE: begin
          if (start_valid) begin
            op_q     <= op;
            dvsr     <= b_mag;
            quot_neg <= in_signed & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
            rem_neg  <= in_signed & dividend[WIDTH-1];
            if (divisor == '0) begin
              result <= in_rem ? dividend : '1;
              state  <= DONE;
            end else if (in_signed && dividend == MIN_NEG && divisor == '1) begin
              result <= in_rem ? '0 : dividend;
              state  <= DONE;
            end else begin
              rem   <= '0;
              quot  <= a_mag;
              cnt   <= CNT_W'(WIDTH);
              state <= CALC;
            end
          end
        end
        CALC: begin
          rem  <= rem_next;
          quot <= quot_next;
          cnt  <= cnt - 1'b1;
          // Last step: take the step outputs directly so the result lands on this edge.
          if (cnt == CNT_W'(1)) begin
            if (op_q[1]) result <= rem_neg  ? -rem_fin   : rem_fin;
            else         result <= quot_neg ? -quot_next : quot_next;
            state <= DONE;
          end
        end
        DONE: begin
          if (result_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign start_ready  = (state == IDLE);
  assign result_valid = (state == DONE);
  assign busy         = (state != IDLE);

endmodule

// File: doc/iter_divider.md
Name: iter_divider

Overview:
- Multi-cycle signed/unsigned integer divide/remainder unit.
- Replaces the combinational `/` and `%` ALU paths so the core clock period is no longer set by a full-width divider.
- Sits beside the ALU; the core's control logic stalls on the valid/ready handshake.
- Uses radix-2 restoring division, one quotient bit per clock, with RISC-V M-extension corner-case semantics.

Parameters:
- WIDTH, 32, operand and result width in bits; must be ≥ 2.
- CNT_W, $clog2(WIDTH+1), iteration counter width; derived, not overridden.

Ports:
- clk  input  1  clock, rising edge
- reset  input  1  synchronous, active-high reset
- flush  input  1  abort in-flight operation (pipeline kill); synchronous
- start_valid  input  1  request present
- start_ready  output  1  unit can accept a request
- op  input  2  00 DIV (signed quot), 01 DIVU, 10 REM (signed rem), 11 REMU
- dividend  input  WIDTH  rs1 value
- divisor  input  WIDTH  rs2 value
- result_valid  output  1  result present
- result_ready  input  1  consumer takes result
- result  output  WIDTH  quotient or remainder per latched op
- busy  output  1  state != IDLE

Behaviour:
- Reset and clock: reset is synchronous, active-high; clock is clk.
- Reset values: state=IDLE, start_ready=1, result_valid=0, result=0, busy=0, all internal registers 0.
- States and their outputs:
  - IDLE: start_ready=1.
  - CALC: start_ready=0.
  - DONE: start_ready=0, result_valid=1.
- Acceptance: a request is accepted on edge E0 where start_valid && start_ready. At E0 the unit latches op, the operand magnitudes and the sign flags.
  - Signed ops: magnitude = two's-complement absolute value.
  - quot_neg = sign(dividend) XOR sign(divisor).
  - rem_neg = sign(dividend).
- Fast path, decided at E0 (state → DONE directly, result_valid high in the cycle after E0):
  - divisor == 0: DIV/DIVU result = all ones; REM/REMU result = dividend unchanged.
  - Signed overflow (DIV/REM, dividend = 1 followed by WIDTH-1 zeros, divisor = all ones): DIV result = dividend; REM result = 0.
- Normal path: state → CALC, counter = WIDTH.
  - On each edge in CALC: one restoring step on {rem, quot}. Shift left one bit, trial subtract the divisor magnitude, restore on borrow, shift in the quotient bit. Decrement the counter.
  - On the edge where the counter reaches 0: apply sign correction (negate quot if quot_neg, negate rem if rem_neg, signed ops only), register result, state → DONE.
  - Latency: result_valid high after exactly WIDTH edges following E0.
- DONE: result and result_valid held stable until result_valid && result_ready. On that edge state → IDLE and result_valid drops. start_ready is 0 in DONE, so one bubble cycle is required between back-to-back ops.
- flush: when high in any state, the next state is IDLE and result_valid=0. No result is produced for the aborted op.
  - flush together with start_valid in IDLE: flush wins, no acceptance.
  - flush in DONE together with result_ready: the handshake completes, state → IDLE (same next state).
- reset takes precedence over flush and over all handshakes. Mid-operation reset behaves identically to power-on reset.
- op, dividend and divisor are ignored outside the acceptance edge. Changing them during CALC has no effect.
- Arithmetic: internal remainder register is WIDTH+1 bits (carries the borrow); the quotient register is WIDTH bits. All negations are modulo 2^WIDTH.

Decomposition:
- Shared package `div_pkg`:
  - op encoding constants OP_DIV, OP_DIVU, OP_REM, OP_REMU.
  - state encoding IDLE/CALC/DONE (2 bits).
- Sub-module `div_step`: purely combinational single restoring iteration.
  - Inputs: rem (WIDTH+1), quot (WIDTH), divisor magnitude.
  - Outputs: next rem, next quot.
  - Instantiated once inside the CALC datapath.

Test Plan (WIDTH=32):
- DIV −7 / 2 → result 0xFFFFFFFD (−3), result_valid exactly 32 edges after acceptance. REM −7, 2 → 0xFFFFFFFF (−1).
- DIVU 100/7 → 14; REMU 100/7 → 2; DIVU 0xFFFFFFFF/1 → 0xFFFFFFFF.
- Divide by zero: DIV 5/0 → 0xFFFFFFFF and REM 5/0 → 5, both with result_valid in the cycle after acceptance.
- Overflow: DIV 0x80000000 / 0xFFFFFFFF → 0x80000000; REM of the same operands → 0; fast-path latency 1.
- Backpressure: hold result_ready=0 for 5 cycles after result_valid → result and result_valid stable throughout, start_ready=0. Raising result_ready → IDLE next edge, start_ready=1.
- Abort:
  - flush asserted 10 cycles into CALC → IDLE next edge, result_valid never rises, a new DIVU 9/3 then returns 3.
  - reset asserted mid-CALC gives the same outcome, with result=0.
